// File: rtl/vector_sweep_engine.sv
// Exhaustive stimulus sweep engine: applies every N_IN-bit vector (binary or Gray order),
// streams (stimulus, response) records over valid/ready and compacts them into a MISR.
module vector_sweep_engine #(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned N_OUT  = 1,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY = 16'h1021
) (
  input  logic               CK,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic               abort,
  output logic [N_IN-1:0]    stim,
  input  logic [N_OUT-1:0]   resp,
  output logic               cap_valid,
  input  logic               cap_ready,
  output logic [N_IN-1:0]    cap_vec,
  output logic [N_OUT-1:0]   cap_resp,
  output logic               busy,
  output logic               done,
  output logic [SIG_W-1:0]   signature,
  output logic [N_IN:0]      vec_count
);

  localparam int unsigned VW = N_IN + 1;
  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, DONE} state_t;

  state_t            state, state_n;
  logic [N_IN-1:0]   idx, idx_n, idx_inc;
  logic              mode_r, mode_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [N_IN-1:0]   stim_n, cap_vec_n;
  logic [N_OUT-1:0]  cap_resp_n;
  logic [SIG_W-1:0]  sig_n;
  logic [N_IN:0]     vec_count_n;
  logic              busy_n, cap_valid_n, done_n;

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      mode_r    <= 1'b0;
      cnt       <= '0;
      stim      <= '0;
      cap_vec   <= '0;
      cap_resp  <= '0;
      signature <= '0;
      vec_count <= '0;
      busy      <= 1'b0;
      cap_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      mode_r    <= mode_n;
      cnt       <= cnt_n;
      stim      <= stim_n;
      cap_vec   <= cap_vec_n;
      cap_resp  <= cap_resp_n;
      signature <= sig_n;
      vec_count <= vec_count_n;
      busy      <= busy_n;
      cap_valid <= cap_valid_n;
      done      <= done_n;
    end
  end

  // Next-state and datapath; flags are registered from the next state.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    mode_n      = mode_r;
    cnt_n       = cnt;
    stim_n      = stim;
    cap_vec_n   = cap_vec;
    cap_resp_n  = cap_resp;
    sig_n       = signature;
    vec_count_n = vec_count;
    idx_inc     = idx + N_IN'(1);

    case (state)
      IDLE, DONE: begin
        if (start && !abort) begin
          state_n     = APPLY;
          idx_n       = '0;
          mode_n      = mode;
          cnt_n       = '0;
          stim_n      = '0;
          sig_n       = '0;
          vec_count_n = '0;
        end
      end
      APPLY: begin
        if (abort) begin
          state_n = IDLE;
        end else if (cnt == CW'(SETTLE - 1)) begin
          cap_vec_n  = stim;
          cap_resp_n = resp;
          state_n    = CAPTURE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      CAPTURE: begin
        if (cap_ready) begin
          sig_n = {signature[SIG_W-2:0], 1'b0}
                ^ (signature[SIG_W-1] ? POLY : '0)
                ^ SIG_W'({cap_vec, cap_resp});
          vec_count_n = vec_count + VW'(1);
          if (abort) begin
            state_n = IDLE;
          end else if (idx == LAST_IDX) begin
            state_n = DONE;
          end else begin
            idx_n   = idx_inc;
            stim_n  = mode_r ? (idx_inc ^ (idx_inc >> 1)) : idx_inc;
            cnt_n   = '0;
            state_n = APPLY;
          end
        end else if (abort) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n      = (state_n == APPLY) || (state_n == CAPTURE);
    cap_valid_n = (state_n == CAPTURE);
    done_n      = (state_n == DONE);
  end

endmodule

// File: tb/tb_vector_sweep_engine.sv
// Randomised scoreboard bench for vector_sweep_engine (N_IN=4, N_OUT=1, SETTLE=1).
`timescale 1ns/1ps
module tb_vector_sweep_engine;

  logic        CK = 1'b0;
  logic        reset, start, mode, abort, cap_ready;
  logic [3:0]  stim, cap_vec;
  logic [0:0]  resp, cap_resp;
  logic        cap_valid, busy, done;
  logic [15:0] signature;
  logic [4:0]  vec_count;

  logic        inv_en;
  logic [3:0]  inv_vec;
  int          checks = 0;
  int          failures = 0;

  typedef struct packed { logic [3:0] v; logic r; } rec_t;
  rec_t exp_q[$];

  always #5 CK = ~CK;

  // Benchmark stand-in: parity of the stimulus, optionally corrupted on one vector.
  assign resp = 1'(^stim ^ (inv_en && stim == inv_vec));

  vector_sweep_engine dut (
    .CK(CK), .reset(reset), .start(start), .mode(mode), .abort(abort),
    .stim(stim), .resp(resp), .cap_valid(cap_valid), .cap_ready(cap_ready),
    .cap_vec(cap_vec), .cap_resp(cap_resp), .busy(busy), .done(done),
    .signature(signature), .vec_count(vec_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: enumerate the sweep order, parity response, and MISR fold.
  task automatic build(input bit md, input bit inv, input int inv_i, output logic [15:0] sig);
    logic [3:0] v;
    logic       r;
    sig = '0;
    for (int i = 0; i < 16; i++) begin
      v = md ? 4'(i ^ (i >> 1)) : 4'(i);
      r = ^v ^ (inv && i == inv_i);
      exp_q.push_back('{v: v, r: r});
      sig = {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0) ^ {11'b0, v, r};
    end
  endtask

  // Monitor: every accepted record must match the head of the scoreboard.
  always @(negedge CK) begin
    if (!reset && cap_valid && cap_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_record", {28'b0, cap_vec}, 32'hffff_ffff);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        check("rec_vec", {28'b0, cap_vec}, {28'b0, e.v});
        check("rec_resp", {31'b0, cap_resp}, {31'b0, e.r});
        check("rec_stim_held", {28'b0, stim}, {28'b0, cap_vec});
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stim"}, {28'b0, stim}, 0);
    check({tag, "_cap_valid"}, {31'b0, cap_valid}, 0);
    check({tag, "_cap_vec"}, {28'b0, cap_vec}, 0);
    check({tag, "_cap_resp"}, {31'b0, cap_resp}, 0);
    check({tag, "_busy"}, {31'b0, busy}, 0);
    check({tag, "_done"}, {31'b0, done}, 0);
    check({tag, "_signature"}, {16'b0, signature}, 0);
    check({tag, "_vec_count"}, {27'b0, vec_count}, 0);
  endtask

  // One sweep; optional stall (5 cycles) at a vector, abort in APPLY of a vector,
  // or async reset while a vector sits in CAPTURE. Returns cycles from start edge to done.
  task automatic sweep(input bit md, input int stall_v, input int abort_v, input int reset_v,
                       input bit rnd, output int cyc);
    bit          stalled = 0;
    int          stall_left = 0;
    logic [15:0] held_sig = '0;
    logic [4:0]  held_cnt = '0;
    mode = md; start = 1'b1; cap_ready = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
    cyc = 0;
    check("start_busy", {31'b0, busy}, 1);
    check("start_stim", {28'b0, stim}, 0);
    check("start_sig_clear", {16'b0, signature}, 0);
    check("start_cnt_clear", {27'b0, vec_count}, 0);
    while (1) begin
      if (cyc >= 2000) begin
        check("sweep_timeout", cyc, 0);
        return;
      end
      if (stall_left > 0) begin
        cap_ready = 1'b0;
        stall_left--;
        check("stall_stim", {28'b0, stim}, stall_v);
        check("stall_vec", {28'b0, cap_vec}, stall_v);
        check("stall_cnt", {27'b0, vec_count}, {27'b0, held_cnt});
        check("stall_sig", {16'b0, signature}, {16'b0, held_sig});
      end else if (stall_v >= 0 && !stalled && cap_valid && cap_vec == 4'(stall_v)) begin
        stalled = 1;
        held_sig = signature;
        held_cnt = vec_count;
        check("stall_entry_cnt", {27'b0, vec_count}, stall_v);
        cap_ready = 1'b0;
        stall_left = 4;
      end else begin
        cap_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (abort_v >= 0 && busy && !cap_valid && stim == 4'(abort_v)) begin
        abort = 1'b1;
        @(posedge CK); #1;
        abort = 1'b0;
        return;
      end
      if (reset_v >= 0 && cap_valid && cap_vec == 4'(reset_v)) begin
        cap_ready = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset_outputs("async_reset");
        @(negedge CK); #1;
        reset = 1'b0;
        return;
      end
      @(posedge CK); #1;
      cyc++;
      if (done) return;
    end
  endtask

  logic [15:0] sig1, sig_m;
  int          cyc;

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0; cap_ready = 1'b1;
    inv_en = 1'b0; inv_vec = 4'd9;
    #3 check_reset_outputs("reset");
    repeat (2) @(posedge CK);
    #1 reset = 1'b0;

    // Ascending sweep, ready tied high.
    build(0, 0, 0, sig1);
    sweep(0, -1, -1, -1, 0, cyc);
    check("asc_cycles", cyc, 32);
    check("asc_count", {27'b0, vec_count}, 16);
    check("asc_sig", {16'b0, signature}, {16'b0, sig1});
    check("asc_busy", {31'b0, busy}, 0);
    check("asc_stim_last", {28'b0, stim}, 15);
    check("asc_q_empty", exp_q.size(), 0);
    abort = 1'b1; @(posedge CK); #1 abort = 1'b0;
    check("abort_in_done", {31'b0, done}, 1);
    check("abort_in_done_cnt", {27'b0, vec_count}, 16);

    // Gray sweep under random back-pressure.
    build(1, 0, 0, sig_m);
    sweep(1, -1, -1, -1, 1, cyc);
    check("gray_count", {27'b0, vec_count}, 16);
    check("gray_sig", {16'b0, signature}, {16'b0, sig_m});
    check("gray_done", {31'b0, done}, 1);
    check("gray_stim_last", {28'b0, stim}, 8);
    check("gray_q_empty", exp_q.size(), 0);

    // Five-cycle stall at vector 7.
    build(0, 0, 0, sig_m);
    sweep(0, 7, -1, -1, 0, cyc);
    check("stall_cycles", cyc, 37);
    check("stall_final_sig", {16'b0, signature}, {16'b0, sig1});
    check("stall_q_empty", exp_q.size(), 0);

    // Abort in APPLY of vector 5.
    build(0, 0, 0, sig_m);
    sweep(0, -1, 5, -1, 0, cyc);
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_valid", {31'b0, cap_valid}, 0);
    check("abort_done", {31'b0, done}, 0);
    check("abort_count", {27'b0, vec_count}, 5);
    check("abort_stim", {28'b0, stim}, 5);
    check("abort_q_left", exp_q.size(), 11);
    exp_q.delete();
    start = 1'b1; abort = 1'b1;
    @(posedge CK); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", {31'b0, busy}, 0);
    check("start_abort_count", {27'b0, vec_count}, 5);
    build(0, 0, 0, sig_m);
    sweep(0, -1, -1, -1, 0, cyc);
    check("restart_sig", {16'b0, signature}, {16'b0, sig1});
    check("restart_count", {27'b0, vec_count}, 16);

    // Async reset while vector 9 waits in CAPTURE, then a full sweep.
    build(0, 0, 0, sig_m);
    sweep(0, -1, -1, 9, 0, cyc);
    check("reset_q_left", exp_q.size(), 7);
    exp_q.delete();
    build(0, 0, 0, sig_m);
    sweep(0, -1, -1, -1, 1, cyc);
    check("post_reset_sig", {16'b0, signature}, {16'b0, sig1});
    check("post_reset_count", {27'b0, vec_count}, 16);

    // Corrupted response on vector 9 must change the signature.
    inv_en = 1'b1;
    build(0, 1, 9, sig_m);
    sweep(0, -1, -1, -1, 0, cyc);
    check("inv_sig", {16'b0, signature}, {16'b0, sig_m});
    check("inv_sig_differs", {31'b0, signature != sig1}, 1);
    check("inv_count", {27'b0, vec_count}, 16);
    inv_en = 1'b0;

    repeat (2) @(posedge CK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vector_sweep_engine.md
# vector_sweep_engine

Synthesizable, parametrised stimulus/response sweep engine for trojan-detection benchmark characterisation. It drives every input combination of an N_IN-bit combinational or sequential DUT, in ascending or Gray order, with a programmable settle time per vector. Each (stimulus, response) pair is streamed out through a valid/ready capture port and compacted into a MISR signature. It sits between a benchmark instance and the capture/logging path, and replaces fixed-width hand-written sweep benches.

## Interface
- N_IN, 4, DUT input width; sweep length is 2^N_IN vectors (1..16)
- N_OUT, 1, DUT output width; N_IN+N_OUT <= SIG_W
- SETTLE, 1, cycles each vector is held before the response is sampled (>= 1)
- SIG_W, 16, MISR signature width
- POLY, 16'h1021, MISR feedback polynomial (SIG_W bits)

Ports:
- CK  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin sweep (sampled in IDLE/DONE only)
- mode  in  1  0 = ascending binary order, 1 = Gray-code order; latched at start
- abort  in  1  terminate sweep, return to IDLE
- stim  out  N_IN  stimulus to DUT
- resp  in  N_OUT  DUT response
- cap_valid  out  1  capture record valid
- cap_ready  in  1  capture sink accepts record
- cap_vec  out  N_IN  stimulus of current record
- cap_resp  out  N_OUT  sampled response of current record
- busy  out  1  high in APPLY/CAPTURE
- done  out  1  sweep complete; held until next start or reset
- signature  out  SIG_W  MISR state
- vec_count  out  N_IN+1  records accepted this sweep

## Operation
- States: IDLE, APPLY, CAPTURE, DONE.
- IDLE/DONE + start: clear idx, signature, vec_count, and done; latch mode; go to APPLY.
- APPLY: stim = idx (mode 0) or idx^(idx>>1) (mode 1). Settle counter runs SETTLE cycles. On the last settle cycle, sample resp into cap_resp and stim into cap_vec, then go to CAPTURE.
- CAPTURE: cap_valid=1. cap_vec, cap_resp, and stim are held stable until a rising edge with cap_ready=1 (accept).
- On accept:
  - signature <= {signature[SIG_W-2:0],1'b0} ^ (signature[SIG_W-1] ? POLY : 0) ^ zero-extend({cap_vec,cap_resp})
  - vec_count += 1
  - if idx == 2^N_IN-1, go to DONE; otherwise idx += 1 and go to APPLY.
- DONE: done=1, busy=0, stim holds the last vector, and signature/vec_count are frozen.
- abort in APPLY/CAPTURE: next state is IDLE. cap_valid and busy drop and done stays 0. signature, vec_count, and stim are retained. An abort on the accept edge still takes the record: the signature and count update, then the block enters IDLE.
- Boundaries:
  - start while busy is ignored.
  - start and abort together: abort wins.
  - abort in IDLE/DONE has no effect.
  - idx never wraps; the sweep ends at 2^N_IN-1.
  - vec_count reaches exactly 2^N_IN at DONE.

## Timing
- Reset values: stim=0, cap_valid=0, cap_vec=0, cap_resp=0, busy=0, done=0, signature=0, vec_count=0, state IDLE. Reset is asynchronous; outputs go to these values without a clock edge.
- Start sampled at edge E0. stim is valid and busy=1 after E0. resp is sampled at edge E0+SETTLE. cap_valid=1 after that edge.
- With cap_ready tied high, each vector occupies SETTLE+1 cycles. done rises after edge E0 + 2^N_IN*(SETTLE+1).
- Each cycle with cap_ready=0 in CAPTURE adds one cycle; no record is lost or duplicated.
- signature and vec_count change only on accept edges.

## Test plan
- N_IN=4, N_OUT=1, SETTLE=1, mode 0, cap_ready=1, resp=^stim:
  - 16 records with cap_vec 0000..1111 ascending and cap_resp 0,1,1,0,1,0,0,1,...
  - done rises 32 cycles after start; vec_count=16.
- Same setup, mode 1:
  - cap_vec sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,...,1000; adjacent records differ in exactly one bit.
  - vec_count=16.
- Back-pressure: cap_ready=0 for 5 cycles at idx 7 → cap_vec=0111 and stim held, signature and vec_count unchanged until accept. The final signature equals scenario 1's, and done is 5 cycles later.
- abort asserted in APPLY of idx 5 → IDLE next cycle, vec_count=5, done=0. A following start restarts from cap_vec=0000 with signature=0; start and abort asserted together → stays IDLE.
- Async reset mid-CAPTURE (idx 9) → all outputs at reset values before the next CK edge. A following start runs a full 16-vector sweep.
- Signature:
  - Two identical sweeps → identical signature.
  - Forcing resp inverted at idx 9 only → signature differs from the clean sweep; vec_count=16 in both.
